motor_speed_ctrl: RTL and testbench
===================================

# motor_speed_ctrl

Remote-key motor speed controller between the NEC IR decoder and the PWM generator. It validates decoded 32-bit NEC frames and honours NEC repeat codes for speed keys. It maintains on/off state and a target duty, and ramps the delivered duty one percent per tick so the motor never steps abruptly. Outputs SW and RateSet feed the PWM stage and motor drive gating directly.

## Interface
- TICK_DIV, 100: CLK cycles per ramp tick (10 ms at the 10 kHz decoder clock).
- STEP, 10: target duty change per UP/DN key, percent.
- MIN_DUTY, 30: lowest running target, and the initial target after reset.
- ADDR, 8'h00: accepted NEC address byte.
- REPEAT_TICKS, 12: ticks after the last accepted frame or repeat during which a repeat code is honoured.

- CLK  in  1  block clock, all logic on rising edge.
- RST  in  1  asynchronous, active-low reset.
- frame  in  32  decoded NEC word; [7:0] address, [15:8] ~address, [23:16] command, [31:24] ~command.
- frame_vld  in  1  one-cycle strobe, frame valid.
- rpt_vld  in  1  one-cycle strobe, NEC repeat code received.
- SW  out  1  motor enable.
- RateSet  out  7  delivered duty, 0..100.
- ramping  out  1  high while RateSet differs from the active ramp goal.
- key_err  out  1  one-cycle pulse on a rejected frame.

## Operation
- Frame accepted iff address == ADDR, byte1 == ~byte0, byte3 == ~byte2. Otherwise key_err pulses and nothing else changes.
- Command codes (package constants): KEY_PWR 8'h45, KEY_UP 8'h46, KEY_DN 8'h47, KEY_STOP 8'h44. Other valid commands are ignored silently.
- States: OFF, RAMP, RUN, SHUTDOWN.
  - OFF: SW=0, RateSet=0.
  - RAMP: SW=1; RateSet moves 1 per tick toward target.
  - RUN: SW=1, RateSet == target.
  - SHUTDOWN: SW=1; RateSet moves 1 per tick toward 0.
- PWR:
  - OFF to RAMP, with target = saved target.
  - RAMP/RUN to SHUTDOWN; target is kept as the saved value.
  - SHUTDOWN to RAMP, resuming from the current RateSet.
- UP: target = min(target+STEP, 100). DN: target = max(target-STEP, MIN_DUTY).
  - Accepted in every state. Saved target still updates in OFF and SHUTDOWN.
  - RUN goes to RAMP if target changes. Saturated keys change nothing.
- STOP: any state goes to OFF next edge; RateSet=0, SW=0. Target is kept.
- RAMP reaching target goes to RUN. SHUTDOWN reaching 0 goes to OFF with SW=0.
- Repeat handling:
  - rpt_vld re-applies the last accepted command only if it was UP or DN and the repeat window counter < REPEAT_TICKS.
  - Otherwise rpt_vld is ignored.
  - The window counter clears on every accepted frame or honoured repeat and saturates at REPEAT_TICKS.
  - PWR and STOP never repeat.
- Tick: free-running counter 0..TICK_DIV-1; tick pulses when counter == TICK_DIV-1.

## Timing
- Reset values:
  - Outputs: SW=0, RateSet=0, ramping=0, key_err=0.
  - Internal: state=OFF, target=MIN_DUTY, last command=none, window=REPEAT_TICKS, tick counter=0.
- Strobe sampled at edge N; state, target and SW update at edge N+1; key_err high for cycle N+1 only.
- First ramp step on the first tick after entry. No step is taken on the entry edge itself.
- frame_vld and rpt_vld in the same cycle: the frame wins, the repeat is dropped.
- Key and tick in the same cycle: the step uses the pre-update target; the new target applies from the next tick.
- STOP and tick in the same cycle: STOP wins, RateSet=0.
- Reset asserted mid-ramp: all registers return to reset values immediately. Saved target is lost.
- RateSet never exceeds 100 and never goes below 0. In RUN, RateSet ≥ MIN_DUTY.

## Structure
- Package motor_pkg holds:
  - KEY_* codes
  - the state enum
  - DUTY_MAX=100
  - the NEC byte-field offsets
- Sub-module tick_gen: parameterised TICK_DIV counter producing the tick pulse. It is shared with other timed stages.
- Top level holds the frame check, repeat window, state machine and ramp datapath.

## Test plan
- Reset, then PWR frame 32'hBA45FF00 -> SW=1 at N+1; RateSet reaches 30 after 30 ticks (~3000 cycles); state RUN; ramping falls.
- In RUN at 30, send UP 3 times -> target 60; RateSet climbs to 60. Send UP 5 more -> target saturates at 100.
- Bad complement frame 32'hBA46FF01 -> key_err pulses 1 cycle; target and state unchanged.
- UP frame, then rpt_vld every 11 ticks, 4 times -> target +50 total. A repeat after 13 idle ticks -> ignored. A repeat following PWR -> ignored.
- At RateSet 60, send PWR -> SHUTDOWN, reaches 0 after 60 ticks, then SW=0. PWR mid-shutdown at RateSet 25 -> ramps back up to 60.
- STOP during RAMP at RateSet 17 -> next edge RateSet=0, SW=0. Async RST low mid-ramp -> all outputs 0 without a clock edge.

Source files
------------

// File: rtl/motor_pkg.sv
// Shared definitions for the remote-key motor speed controller:
// key codes, FSM states, duty limit and NEC frame byte layout.
package motor_pkg;

   localparam logic [7:0] KEY_PWR  = 8'h45;
   localparam logic [7:0] KEY_UP   = 8'h46;
   localparam logic [7:0] KEY_DN   = 8'h47;
   localparam logic [7:0] KEY_STOP = 8'h44;
   localparam logic [7:0] KEY_NONE = 8'h00;

   localparam int unsigned DUTY_MAX = 100;

   localparam int unsigned NEC_ADDR_LSB   = 0;
   localparam int unsigned NEC_ADDR_N_LSB = 8;
   localparam int unsigned NEC_CMD_LSB    = 16;
   localparam int unsigned NEC_CMD_N_LSB  = 24;

   typedef enum logic [1:0] {
      ST_OFF,
      ST_RAMP,
      ST_RUN,
      ST_SHUTDOWN
   } motor_state_t;

   function automatic logic [7:0] nec_byte(input logic [31:0] word, input int unsigned lsb);
      return word[lsb +: 8];
   endfunction

endpackage

// File: rtl/motor_speed_ctrl_tick_gen.sv
// Free-running divider: o_tick pulses for one cycle every TICK_DIV clocks.
module tick_gen #(
   parameter int unsigned TICK_DIV = 100
) (
   input  logic i_clk,
   input  logic i_rst_n,
   output logic o_tick
);

   localparam int unsigned      CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   always_comb begin
      o_tick = (r_cnt == CNT_LAST);
   end

endmodule

// File: rtl/motor_speed_ctrl.sv
// Remote-key motor speed controller: validates NEC frames, honours repeat
// codes for UP/DN, and ramps the delivered duty one percent per tick.
module motor_speed_ctrl
   import motor_pkg::*;
#(
   parameter int unsigned TICK_DIV     = 100,
   parameter int unsigned STEP         = 10,
   parameter int unsigned MIN_DUTY     = 30,
   parameter logic [7:0]  ADDR         = 8'h00,
   parameter int unsigned REPEAT_TICKS = 12
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] frame,
   input  logic        frame_vld,
   input  logic        rpt_vld,
   output logic        SW,
   output logic [6:0]  RateSet,
   output logic        ramping,
   output logic        key_err
);

   localparam int unsigned      WIN_W    = $clog2(REPEAT_TICKS + 1);
   localparam logic [WIN_W-1:0] WIN_SAT  = WIN_W'(REPEAT_TICKS);
   localparam logic [6:0]       TGT_MAX  = 7'(DUTY_MAX);
   localparam logic [6:0]       TGT_MIN  = 7'(MIN_DUTY);
   localparam logic [6:0]       TGT_STEP = 7'(STEP);

   logic             w_tick;
   logic [7:0]       w_addr, w_addr_n, w_cmd, w_cmd_n;
   logic             w_frame_ok, w_accept, w_reject, w_rpt_ok;
   logic             w_pwr, w_up, w_dn, w_stop;
   logic [7:0]       w_tgt_sum;
   logic [6:0]       w_tgt_nxt, w_rate_nxt;
   motor_state_t     w_state_nxt;

   logic             r_cmd_vld;
   logic [7:0]       r_cmd;
   logic             r_bad;
   logic [7:0]       r_last_cmd;
   logic [WIN_W-1:0] r_win;
   logic             r_key_err;
   logic [6:0]       r_rate;
   logic [6:0]       r_target;
   motor_state_t     r_state;

   tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
      .i_clk   (CLK),
      .i_rst_n (RST),
      .o_tick  (w_tick)
   );

   always_comb begin
      w_addr     = nec_byte(frame, NEC_ADDR_LSB);
      w_addr_n   = nec_byte(frame, NEC_ADDR_N_LSB);
      w_cmd      = nec_byte(frame, NEC_CMD_LSB);
      w_cmd_n    = nec_byte(frame, NEC_CMD_N_LSB);
      w_frame_ok = (w_addr == ADDR) && (w_addr_n == ~w_addr) && (w_cmd_n == ~w_cmd);
      w_accept   = frame_vld && w_frame_ok;
      w_reject   = frame_vld && !w_frame_ok;
      w_rpt_ok   = rpt_vld && !frame_vld && (r_last_cmd == KEY_UP || r_last_cmd == KEY_DN)
                   && (r_win < WIN_SAT);
   end

   // Keys are registered here and acted on one edge later, so a strobe
   // sampled at edge N changes state/target and raises key_err at edge N+1.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_cmd_vld  <= 1'b0;
         r_cmd      <= KEY_NONE;
         r_bad      <= 1'b0;
         r_last_cmd <= KEY_NONE;
         r_win      <= WIN_SAT;
      end else begin
         r_cmd_vld <= w_accept || w_rpt_ok;
         r_cmd     <= frame_vld ? w_cmd : r_last_cmd;
         r_bad     <= w_reject;
         if (w_accept) begin
            r_last_cmd <= w_cmd;
            r_win      <= '0;
         end else if (w_rpt_ok) begin
            r_win <= '0;
         end else if (w_tick && (r_win < WIN_SAT)) begin
            r_win <= r_win + WIN_W'(1);
         end
      end
   end

   always_comb begin
      w_pwr     = r_cmd_vld && (r_cmd == KEY_PWR);
      w_up      = r_cmd_vld && (r_cmd == KEY_UP);
      w_dn      = r_cmd_vld && (r_cmd == KEY_DN);
      w_stop    = r_cmd_vld && (r_cmd == KEY_STOP);
      w_tgt_sum = {1'b0, r_target} + {1'b0, TGT_STEP};
      w_tgt_nxt = r_target;
      if (w_up) begin
         w_tgt_nxt = (w_tgt_sum > {1'b0, TGT_MAX}) ? TGT_MAX : w_tgt_sum[6:0];
      end else if (w_dn) begin
         w_tgt_nxt = (r_target < (TGT_MIN + TGT_STEP)) ? TGT_MIN : (r_target - TGT_STEP);
      end
   end

   // Ramp steps toward the pre-update target; a new target applies from the next tick.
   always_comb begin
      w_rate_nxt = r_rate;
      if (w_stop) begin
         w_rate_nxt = '0;
      end else if (w_tick) begin
         if (r_state == ST_RAMP) begin
            if (r_rate < r_target) begin
               w_rate_nxt = r_rate + 7'd1;
            end else if (r_rate > r_target) begin
               w_rate_nxt = r_rate - 7'd1;
            end
         end else if ((r_state == ST_SHUTDOWN) && (r_rate != '0)) begin
            w_rate_nxt = r_rate - 7'd1;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_rate    <= '0;
         r_target  <= TGT_MIN;
         r_key_err <= 1'b0;
      end else begin
         r_rate    <= w_rate_nxt;
         r_target  <= w_tgt_nxt;
         r_key_err <= r_bad;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state <= ST_OFF;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_stop) begin
         w_state_nxt = ST_OFF;
      end else if (w_pwr) begin
         case (r_state)
            ST_OFF:      w_state_nxt = ST_RAMP;
            ST_SHUTDOWN: w_state_nxt = ST_RAMP;
            default:     w_state_nxt = ST_SHUTDOWN;
         endcase
      end else begin
         case (r_state)
            ST_RUN:      if (w_tgt_nxt != r_target) w_state_nxt = ST_RAMP;
            ST_RAMP:     if (w_rate_nxt == w_tgt_nxt) w_state_nxt = ST_RUN;
            ST_SHUTDOWN: if (w_rate_nxt == '0) w_state_nxt = ST_OFF;
            default:     w_state_nxt = r_state;
         endcase
      end
   end

   always_comb begin
      SW      = (r_state != ST_OFF);
      RateSet = r_rate;
      key_err = r_key_err;
      ramping = ((r_state == ST_RAMP) && (r_rate != r_target)) ||
                ((r_state == ST_SHUTDOWN) && (r_rate != '0));
   end

endmodule

// File: tb/tb_motor_speed_ctrl.sv
// Self-checking bench for motor_speed_ctrl: frame-check vector table plus
// hand-written ramp, repeat-window, STOP and async-reset sequences.
module tb_motor_speed_ctrl;

   localparam int unsigned TD = 100;

   localparam logic [31:0] F_PWR  = 32'hBA45FF00;
   localparam logic [31:0] F_UP   = 32'hB946FF00;
   localparam logic [31:0] F_DN   = 32'hB847FF00;
   localparam logic [31:0] F_STOP = 32'hBB44FF00;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic [31:0] frame = '0;
   logic        frame_vld = 1'b0;
   logic        rpt_vld = 1'b0;
   logic        SW;
   logic [6:0]  RateSet;
   logic        ramping;
   logic        key_err;

   int checks = 0;
   int errors = 0;

   motor_speed_ctrl #(
      .TICK_DIV     (TD),
      .STEP         (10),
      .MIN_DUTY     (30),
      .ADDR         (8'h00),
      .REPEAT_TICKS (12)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .frame     (frame),
      .frame_vld (frame_vld),
      .rpt_vld   (rpt_vld),
      .SW        (SW),
      .RateSet   (RateSet),
      .ramping   (ramping),
      .key_err   (key_err)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic       sw;
      logic [6:0] rate;
      logic       ramp;
      logic       kerr;
   } exp_t;

   typedef struct {
      string       name;
      logic [31:0] f;
      logic        fv;
      logic        rv;
      logic        sw;
      logic [6:0]  rate;
      logic        ramp;
      logic        kerr;
   } vec_t;

   exp_t  sb_q[$];
   string sb_name[$];
   vec_t  tbl[$];

   function automatic exp_t mk(logic sw, logic [6:0] rate, logic ramp, logic kerr);
      exp_t e;
      e.sw = sw; e.rate = rate; e.ramp = ramp; e.kerr = kerr;
      return e;
   endfunction

   task automatic add_vec(string name, logic [31:0] f, logic fv, logic rv,
                          logic sw, logic [6:0] rate, logic ramp, logic kerr);
      vec_t v;
      v.name = name; v.f = f; v.fv = fv; v.rv = rv;
      v.sw = sw; v.rate = rate; v.ramp = ramp; v.kerr = kerr;
      tbl.push_back(v);
   endtask

   task automatic check_val(string name, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic sb_check();
      exp_t  e;
      string n;
      checks++;
      if (sb_q.size() == 0) begin
         errors++;
         $display("FAIL scoreboard: no expectation queued");
         return;
      end
      e = sb_q.pop_front();
      n = sb_name.pop_front();
      if ({SW, RateSet, ramping, key_err} !== {e.sw, e.rate, e.ramp, e.kerr}) begin
         errors++;
         $display("FAIL %s: got SW=%b RateSet=%0d ramping=%b key_err=%b expected SW=%b RateSet=%0d ramping=%b key_err=%b",
                  n, SW, RateSet, ramping, key_err, e.sw, e.rate, e.ramp, e.kerr);
      end
   endtask

   // Called at a negedge: strobe is sampled at edge N, outputs checked after edge N+1.
   task automatic send(string name, logic [31:0] f, logic fv, logic rv, exp_t e);
      sb_q.push_back(e);
      sb_name.push_back(name);
      frame = f; frame_vld = fv; rpt_vld = rv;
      @(negedge CLK);
      frame_vld = 1'b0; rpt_vld = 1'b0;
      @(negedge CLK);
      sb_check();
   endtask

   task automatic pulse(logic [31:0] f, logic fv, logic rv);
      frame = f; frame_vld = fv; rpt_vld = rv;
      @(negedge CLK);
      frame_vld = 1'b0; rpt_vld = 1'b0;
   endtask

   task automatic idle(int n);
      repeat (n) @(negedge CLK);
   endtask

   // Bounded wait for RateSet to reach a value after about nticks ramp ticks.
   task automatic wait_rate(string name, int target, int nticks);
      int n;
      int lo;
      int hi;
      n  = 0;
      lo = (nticks - 1) * int'(TD) - 10;
      hi = nticks * int'(TD) + 10;
      while ((RateSet !== 7'(target)) && (n < hi)) begin
         @(negedge CLK);
         n++;
      end
      checks++;
      if ((RateSet !== 7'(target)) || (n < lo)) begin
         errors++;
         $display("FAIL %s: RateSet=%0d after %0d cycles, required %0d within %0d..%0d cycles",
                  name, RateSet, n, target, lo, hi);
      end
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1);
   end

   initial begin
      // Frame-check table, applied from OFF with target 30.
      add_vec("bad_addr_compl", 32'hBA45FF01, 1'b1, 1'b0, 1'b0, 7'd0, 1'b0, 1'b1);
      add_vec("wrong_addr",     32'hBA45FE01, 1'b1, 1'b0, 1'b0, 7'd0, 1'b0, 1'b1);
      add_vec("bad_cmd_compl",  32'hBB45FF00, 1'b1, 1'b0, 1'b0, 7'd0, 1'b0, 1'b1);
      add_vec("up_in_off",      F_UP,         1'b1, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0);
      add_vec("rpt_up_in_off",  32'h0,        1'b0, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0);
      add_vec("unknown_cmd",    32'hED12FF00, 1'b1, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0);
      add_vec("dn_with_rpt",    F_DN,         1'b1, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0);
      add_vec("dn_in_off",      F_DN,         1'b1, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0);
      add_vec("pwr_from_off",   F_PWR,        1'b1, 1'b0, 1'b1, 7'd0, 1'b1, 1'b0);
      add_vec("stop_in_ramp",   F_STOP,       1'b1, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0);

      RST = 1'b0;
      idle(3);
      sb_q.push_back(mk(1'b0, 7'd0, 1'b0, 1'b0));
      sb_name.push_back("reset_state");
      sb_check();
      RST = 1'b1;
      idle(2);

      for (int i = 0; i < tbl.size(); i++) begin
         send(tbl[i].name, tbl[i].f, tbl[i].fv, tbl[i].rv,
              mk(tbl[i].sw, tbl[i].rate, tbl[i].ramp, tbl[i].kerr));
         @(negedge CLK);
         check_val({tbl[i].name, "_kerr_clear"}, 32'(key_err), 32'd0);
      end
      // Target is 30 again: UP, repeat, DN (frame beats repeat), DN.

      send("pwr_on", F_PWR, 1'b1, 1'b0, mk(1'b1, 7'd0, 1'b1, 1'b0));
      wait_rate("ramp_to_30", 30, 30);
      check_val("run_at_30_ramping", 32'(ramping), 32'd0);
      check_val("run_at_30_sw", 32'(SW), 32'd1);

      send("up_from_run", F_UP, 1'b1, 1'b0, mk(1'b1, 7'd30, 1'b1, 1'b0));
      pulse(F_UP, 1'b1, 1'b0);
      idle(1);
      pulse(F_UP, 1'b1, 1'b0);
      wait_rate("ramp_to_60", 60, 30);
      check_val("run_at_60_ramping", 32'(ramping), 32'd0);

      send("bad_frame_in_run", 32'hBA46FF01, 1'b1, 1'b0, mk(1'b1, 7'd60, 1'b0, 1'b1));
      sb_q.push_back(mk(1'b1, 7'd60, 1'b0, 1'b0));
      sb_name.push_back("bad_frame_pulse_end");
      @(negedge CLK);
      sb_check();

      send("pwr_to_shutdown", F_PWR, 1'b1, 1'b0, mk(1'b1, 7'd60, 1'b1, 1'b0));
      wait_rate("shutdown_to_25", 25, 35);
      send("pwr_resume", F_PWR, 1'b1, 1'b0, mk(1'b1, 7'd25, 1'b1, 1'b0));
      wait_rate("resume_to_60", 60, 35);
      check_val("resume_done_ramping", 32'(ramping), 32'd0);

      send("pwr_shutdown_full", F_PWR, 1'b1, 1'b0, mk(1'b1, 7'd60, 1'b1, 1'b0));
      wait_rate("shutdown_to_0", 0, 60);
      check_val("shutdown_done_sw", 32'(SW), 32'd0);
      check_val("shutdown_done_ramping", 32'(ramping), 32'd0);

      for (int k = 0; k < 5; k++) begin
         pulse(F_UP, 1'b1, 1'b0);
         idle(1);
      end
      send("pwr_to_100", F_PWR, 1'b1, 1'b0, mk(1'b1, 7'd0, 1'b1, 1'b0));
      wait_rate("ramp_to_100", 100, 100);
      check_val("run_at_100_ramping", 32'(ramping), 32'd0);
      send("up_saturated", F_UP, 1'b1, 1'b0, mk(1'b1, 7'd100, 1'b0, 1'b0));
      idle(5);
      check_val("saturated_ramping", 32'(ramping), 32'd0);
      check_val("saturated_rate", 32'(RateSet), 32'd100);

      send("stop_in_run", F_STOP, 1'b1, 1'b0, mk(1'b0, 7'd0, 1'b0, 1'b0));
      for (int k = 0; k < 7; k++) begin
         pulse(F_DN, 1'b1, 1'b0);
         idle(1);
      end

      // Target 30 -> UP 40 -> four repeats 11 ticks apart -> 80; later repeats ignored.
      pulse(F_UP, 1'b1, 1'b0);
      idle(TD * 11 - 1);
      for (int k = 0; k < 4; k++) begin
         pulse(32'h0, 1'b0, 1'b1);
         idle((k == 3) ? (TD * 13 - 1) : (TD * 11 - 1));
      end
      pulse(32'h0, 1'b0, 1'b1);
      idle(2);
      send("pwr_after_rpts", F_PWR, 1'b1, 1'b0, mk(1'b1, 7'd0, 1'b1, 1'b0));
      idle(2);
      pulse(32'h0, 1'b0, 1'b1);
      wait_rate("ramp_to_80", 80, 80);
      check_val("run_at_80_ramping", 32'(ramping), 32'd0);
      idle(150);
      check_val("hold_at_80_rate", 32'(RateSet), 32'd80);
      check_val("hold_at_80_ramping", 32'(ramping), 32'd0);

      send("stop_at_80", F_STOP, 1'b1, 1'b0, mk(1'b0, 7'd0, 1'b0, 1'b0));
      send("pwr_again", F_PWR, 1'b1, 1'b0, mk(1'b1, 7'd0, 1'b1, 1'b0));
      wait_rate("ramp_to_17", 17, 17);
      send("stop_mid_ramp", F_STOP, 1'b1, 1'b0, mk(1'b0, 7'd0, 1'b0, 1'b0));

      send("pwr_before_reset", F_PWR, 1'b1, 1'b0, mk(1'b1, 7'd0, 1'b1, 1'b0));
      wait_rate("ramp_to_20", 20, 20);
      #2;
      RST = 1'b0;
      #1;
      sb_q.push_back(mk(1'b0, 7'd0, 1'b0, 1'b0));
      sb_name.push_back("async_reset_mid_ramp");
      sb_check();
      @(negedge CLK);
      RST = 1'b1;
      idle(1);
      send("pwr_after_reset", F_PWR, 1'b1, 1'b0, mk(1'b1, 7'd0, 1'b1, 1'b0));
      wait_rate("ramp_to_min_after_reset", 30, 30);
      check_val("reset_target_run_ramping", 32'(ramping), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
